ec_mem_resp: RTL
================

Name: ec_mem_resp

Overview:
- Response side of the data-memory SRAM-like handshake. Requests are issued from EX and held in the EX/EC segment; this block sits in EC and consumes them.
- Counts outstanding data requests and matches data_ok beats to the instruction in EC.
- Buffers a response that arrives while the pipeline is stalled, drops responses that belong to instructions flushed by refresh, and extracts and extends load data for writeback.
- Drives the EC-stage memory stall into the global stall logic.

Parameters:
- MAX_OUTST, 2, maximum data requests in flight; sets the width of the outstanding and discard counters.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- issue_ok  in  1  data_req && data_addr_ok in EX this cycle; one new request accepted
- data_data_ok  in  1  response beat from the data SRAM-like port
- data_rdata  in  32  response data, valid with data_data_ok
- refresh  in  1  pipeline flush (exception/eret); same signal that clears the segment registers
- ec_adv  in  1  EC instruction moves to WB this cycle (segment not stalled)
- ec_data_req  in  1  instruction in EC owns an issued request
- ec_load  in  1  instruction in EC is a load
- ec_loadX  in  1  1 = zero-extend (lbu/lhu), 0 = sign-extend
- ec_lsV  in  4  byte-lane mask, already aligned to the address
- ec_data_addr  in  2  address low bits
- ec_mem_stall  out  1  EC waits for its response
- ec_rdata  out  32  extracted and extended load result
- ec_rdata_valid  out  1  ec_rdata is meaningful this cycle
- outst_full  out  1  outstanding count == MAX_OUTST; EX must not issue

Behaviour:
- Reset (resetn=0 at a clock edge): outst=0, discard=0, buf_valid=0, buf_data=0. All outputs are 0.
- Outstanding counter:
  - outst_next = outst + issue_ok - data_data_ok.
  - Simultaneous issue_ok and data_data_ok leaves outst unchanged.
  - issue_ok while outst_full is illegal; assert in simulation.
  - data_data_ok while outst==0 is illegal; assert in simulation.
- Discard on refresh:
  - discard_next = outst + issue_ok - data_data_ok, computed the same cycle refresh is high.
  - Any issue_ok in the refresh cycle belongs to a flushed instruction and is counted for discard.
  - While discard>0, each data_data_ok decrements both discard and outst. The beat is not buffered and causes no visible effect.
  - Refresh while discard>0 applies the same formula; the counts are not double-counted.
  - buf_valid is cleared on refresh.
- Response capture:
  - hit = data_data_ok && discard==0 && ec_data_req && !buf_valid.
  - If hit && !ec_adv: buf_valid<=1, buf_data<=data_rdata.
  - On ec_adv: buf_valid<=0. This takes priority over setting buf_valid.
- Stall:
  - ec_mem_stall = ec_data_req && !buf_valid && !hit.
  - Purely combinational from the current cycle; data_rdata is bypassed to the output on the hit cycle (zero-latency).
- Extraction:
  - raw = buf_valid ? buf_data : data_rdata.
  - Shift right by 8*ec_data_addr.
  - lsV=4'b1111: pass all 32 bits.
  - lsV with 2 bits set: halfword; extend bit 15.
  - lsV with 1 bit set: byte; extend bit 7.
  - Extension is zero when ec_loadX=1, sign otherwise.
- ec_rdata_valid = ec_load && ec_data_req && (buf_valid || hit). ec_rdata=0 when ec_rdata_valid=0.
- Stores: ec_data_req=1, ec_load=0. They still wait for data_ok, because write responses are also beats. ec_rdata_valid stays 0.
- Reset mid-transaction: counters clear. The external bridge is reset by the same resetn, so no stale beats follow.

Decomposition:
- head.vh gains:
  - lsV constants: LSV_W=4'b1111, LSV_H0=4'b0011, LSV_H1=4'b1100, LSV_B0..LSV_B3.
  - MAX_OUTST default.
- One combinational sub-module, load_extract (raw, addr, lsV, loadX -> rdata), is reused by the uncached path.
- Counters, buffer and stall logic stay in the top module.

Test Plan:
- Single lw, data_addr=0, rdata=32'h8000_00F0 on the first EC cycle with ec_adv=1 -> stall 0, ec_rdata=32'h8000_00F0, valid=1, outst 1->0.
- lb, addr=2'b11, lsV=4'b1000, loadX=0, rdata=32'h8123_4567; response delayed 3 cycles -> stall high 3 cycles, then ec_rdata=32'hFFFF_FF81.
- lhu, addr=2'b10, lsV=4'b1100, loadX=1, data_ok while ec_adv=0 (WB stall) -> buf_valid=1, stall 0, ec_rdata=32'h0000_8123 held until ec_adv, then buf cleared.
- Two issues in flight (outst=2, outst_full=1), refresh plus a third issue_ok blocked -> discard=2; next two data_ok ignored (ec_rdata_valid=0), then outst=0, discard=0.
- Refresh in the same cycle as issue_ok=1 and data_data_ok=1 with outst=1 -> discard=1, outst=1; the following beat is dropped.
- resetn=0 asserted with outst=1 and buf_valid=1 -> next cycle all counters, buffer and outputs are 0.

Source files
------------

// File: rtl/ec_mem_resp_pkg.sv
// Shared constants for the EC-stage data-memory response path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ec_mem_resp_pkg;

    // Default number of data requests allowed in flight.
    localparam int MAX_OUTST_DEF = 2;

    // Byte-lane masks as seen in EC, already aligned to the address.
    localparam logic [3:0] LSV_W  = 4'b1111;
    localparam logic [3:0] LSV_H0 = 4'b0011;
    localparam logic [3:0] LSV_H1 = 4'b1100;
    localparam logic [3:0] LSV_B0 = 4'b0001;
    localparam logic [3:0] LSV_B1 = 4'b0010;
    localparam logic [3:0] LSV_B2 = 4'b0100;
    localparam logic [3:0] LSV_B3 = 4'b1000;

endpackage

// File: rtl/ec_mem_resp_load_extract.sv
// Load data extraction: align the addressed field to bit 0 and zero/sign extend it.
// Latency: purely combinational.
// Backpressure: none; the output follows the inputs.
module load_extract
    import ec_mem_resp_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr,
    input  logic [3:0]  lsv,
    input  logic        loadx,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic        sign_bit;

    // Shift the addressed byte to lane 0, then extend according to access width.
    always_comb begin
        shifted  = raw >> {addr, 3'b000};
        sign_bit = 1'b0;
        rdata    = shifted;
        case (lsv)
            LSV_H0, LSV_H1: begin
                sign_bit = ~loadx & shifted[15];
                rdata    = {{16{sign_bit}}, shifted[15:0]};
            end
            LSV_B0, LSV_B1, LSV_B2, LSV_B3: begin
                sign_bit = ~loadx & shifted[7];
                rdata    = {{24{sign_bit}}, shifted[7:0]};
            end
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/ec_mem_resp.sv
// EC-stage data response handler: counts requests in flight, drops flushed beats, buffers early beats.
// Latency: zero-cycle bypass of data_rdata on the beat cycle; buffered data held until ec_adv.
// Backpressure: ec_mem_stall holds EC until its beat arrives; outst_full blocks new issues in EX.
module ec_mem_resp
    import ec_mem_resp_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        refresh,
    input  logic        ec_adv,
    input  logic        ec_data_req,
    input  logic        ec_load,
    input  logic        ec_loadX,
    input  logic [3:0]  ec_lsV,
    input  logic [1:0]  ec_data_addr,
    output logic        ec_mem_stall,
    output logic [31:0] ec_rdata,
    output logic        ec_rdata_valid,
    output logic        outst_full
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [CW-1:0] outst;
    logic [CW-1:0] discard;
    logic [CW-1:0] outst_sum;
    logic          buf_valid;
    logic [31:0]   buf_data;
    logic          hit;
    logic [31:0]   raw;
    logic [31:0]   extracted;

    // Beat matching, stall and the next outstanding count for this cycle.
    always_comb begin
        outst_sum    = outst + CW'(issue_ok) - CW'(data_data_ok);
        hit          = data_data_ok && (discard == '0) && ec_data_req && !buf_valid;
        ec_mem_stall = ec_data_req && !buf_valid && !hit;
        outst_full   = (outst == CW'(MAX_OUTST));
        raw          = buf_valid ? buf_data : data_rdata;
    end

    load_extract u_load_extract (
        .raw   (raw),
        .addr  (ec_data_addr),
        .lsv   (ec_lsV),
        .loadx (ec_loadX),
        .rdata (extracted)
    );

    // Result is only driven while the EC load actually has its data.
    always_comb begin
        ec_rdata_valid = ec_load && ec_data_req && (buf_valid || hit);
        ec_rdata       = ec_rdata_valid ? extracted : 32'h0;
    end

    // Outstanding and discard counters; on refresh every request still in flight,
    // including one issued this very cycle, belongs to a flushed instruction.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            outst   <= '0;
            discard <= '0;
        end else begin
            outst <= outst_sum;
            if (refresh)
                discard <= outst_sum;
            else if (data_data_ok && (discard != '0))
                discard <= discard - CW'(1);
        end
    end

    // Hold a beat that arrives while EC cannot advance; flush or advance empties it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            buf_data  <= 32'h0;
        end else if (refresh || ec_adv) begin
            buf_valid <= 1'b0;
        end else if (hit) begin
            buf_valid <= 1'b1;
            buf_data  <= data_rdata;
        end
    end

    // Handshake protocol checks.
    a_no_issue_when_full: assert property (@(posedge clk) disable iff (!resetn)
        !(issue_ok && outst_full));
    a_no_beat_when_idle: assert property (@(posedge clk) disable iff (!resetn)
        !(data_data_ok && (outst == '0)));

endmodule
